// File: rtl/libnet_ack_sched.sv
// Shares the 512-bit sysnet TX stream between app packets and coalesced libnet ACK beats.
// Latency: app path is combinational once granted; each grant costs one IDLE cycle; ACK beat is registered.
// Backpressure: net_tready stalls the granted source; app_tready is low unless an app packet holds the grant.
module libnet_ack_sched #(
    parameter int unsigned ACK_THRESH  = 4,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned SEQ_LSB     = 344,
    parameter int unsigned ACK_FLAG    = 376,
    parameter logic [63:0] ACK_TKEEP   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic [31:0]  i_seq_expected,
    input  logic         i_seq_valid,
    input  logic [511:0] i_app_tdata,
    input  logic [63:0]  i_app_tkeep,
    input  logic [63:0]  i_app_tuser,
    input  logic         i_app_tvalid,
    input  logic         i_app_tlast,
    output logic         o_app_tready,
    output logic [511:0] o_net_tdata,
    output logic [63:0]  o_net_tkeep,
    output logic [63:0]  o_net_tuser,
    output logic         o_net_tvalid,
    output logic         o_net_tlast,
    input  logic         i_net_tready,
    output logic [31:0]  o_acks_sent
);

    localparam logic [7:0]  THRESH  = 8'(ACK_THRESH);
    localparam logic [15:0] TIMEOUT = 16'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APP,
        S_ACK
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_enter_ack;

    logic         r_have_seq;
    logic [31:0]  r_last_seq;
    logic [31:0]  r_ack_seq;
    logic         r_pending;
    logic [7:0]   r_upd_cnt;
    logic [15:0]  r_timer;
    logic         r_last_grant_ack;
    logic [31:0]  r_acks_sent;

    logic         w_event;
    logic         w_ack_due;
    logic         w_app_xfer;
    logic         w_ack_accept;
    logic         w_still_pend;
    logic [511:0] w_ack_tdata;

    assign w_event      = i_seq_valid && (!r_have_seq || (i_seq_expected != r_last_seq));
    assign w_ack_due    = r_pending && ((r_upd_cnt >= THRESH) || (r_timer >= TIMEOUT));
    assign w_app_xfer   = (r_state == S_APP) && i_app_tvalid && i_net_tready;
    assign w_ack_accept = (r_state == S_ACK) && i_net_tready;
    // A seq that moved after the snapshot was not carried by this ACK, so it stays pending.
    assign w_still_pend = w_event || (r_last_seq != r_ack_seq);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enter_ack = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ack_due && (!i_app_tvalid || !r_last_grant_ack)) begin
                    w_state_nxt = S_ACK;
                    w_enter_ack = 1'b1;
                end else if (i_app_tvalid) begin
                    w_state_nxt = S_APP;
                end
            end
            S_APP: begin
                if (w_app_xfer && i_app_tlast) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                if (i_net_tready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_have_seq <= 1'b0;
            r_last_seq <= 32'd0;
        end else if (w_event) begin
            r_have_seq <= 1'b1;
            r_last_seq <= i_seq_expected;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_pending <= 1'b0;
            r_upd_cnt <= 8'd0;
            r_timer   <= 16'd0;
        end else if (w_ack_accept) begin
            r_pending <= w_still_pend;
            r_upd_cnt <= w_still_pend ? 8'd1 : 8'd0;
            r_timer   <= 16'd0;
        end else begin
            if (w_event) begin
                r_pending <= 1'b1;
                if (r_upd_cnt < THRESH) begin
                    r_upd_cnt <= r_upd_cnt + 8'd1;
                end
            end
            if (!r_pending) begin
                r_timer <= 16'd0;
            end else if (r_timer < TIMEOUT) begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ack_seq        <= 32'd0;
            r_last_grant_ack <= 1'b1;
            r_acks_sent      <= 32'd0;
        end else begin
            if (w_enter_ack) begin
                r_ack_seq <= r_last_seq;
            end
            if (w_app_xfer && i_app_tlast) begin
                r_last_grant_ack <= 1'b0;
            end else if (w_ack_accept) begin
                r_last_grant_ack <= 1'b1;
            end
            if (w_ack_accept) begin
                r_acks_sent <= r_acks_sent + 32'd1;
            end
        end
    end

    always_comb begin
        w_ack_tdata                   = '0;
        w_ack_tdata[SEQ_LSB +: 32]    = r_ack_seq;
        w_ack_tdata[ACK_FLAG]         = 1'b1;
    end

    always_comb begin
        o_net_tdata  = '0;
        o_net_tkeep  = '0;
        o_net_tuser  = '0;
        o_net_tvalid = 1'b0;
        o_net_tlast  = 1'b0;
        o_app_tready = 1'b0;
        case (r_state)
            S_APP: begin
                o_net_tdata  = i_app_tdata;
                o_net_tkeep  = i_app_tkeep;
                o_net_tuser  = i_app_tuser;
                o_net_tvalid = i_app_tvalid;
                o_net_tlast  = i_app_tlast;
                o_app_tready = i_net_tready;
            end
            S_ACK: begin
                o_net_tdata  = w_ack_tdata;
                o_net_tkeep  = ACK_TKEEP;
                o_net_tvalid = 1'b1;
                o_net_tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_acks_sent = r_acks_sent;

endmodule

// File: tb/tb_libnet_ack_sched.sv
// Bench for libnet_ack_sched: seq-update table plus no-preempt, backpressure, round-robin and reset sequences.
module tb_libnet_ack_sched;

    logic         i_clk = 1'b0;
    logic         i_resetn;
    logic [31:0]  i_seq_expected;
    logic         i_seq_valid;
    logic [511:0] i_app_tdata;
    logic [63:0]  i_app_tkeep;
    logic [63:0]  i_app_tuser;
    logic         i_app_tvalid;
    logic         i_app_tlast;
    logic         o_app_tready;
    logic [511:0] o_net_tdata;
    logic [63:0]  o_net_tkeep;
    logic [63:0]  o_net_tuser;
    logic         o_net_tvalid;
    logic         o_net_tlast;
    logic         i_net_tready;
    logic [31:0]  o_acks_sent;

    libnet_ack_sched #(.ACK_THRESH(4), .ACK_TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_resetn(i_resetn),
        .i_seq_expected(i_seq_expected), .i_seq_valid(i_seq_valid),
        .i_app_tdata(i_app_tdata), .i_app_tkeep(i_app_tkeep), .i_app_tuser(i_app_tuser),
        .i_app_tvalid(i_app_tvalid), .i_app_tlast(i_app_tlast), .o_app_tready(o_app_tready),
        .o_net_tdata(o_net_tdata), .o_net_tkeep(o_net_tkeep), .o_net_tuser(o_net_tuser),
        .o_net_tvalid(o_net_tvalid), .o_net_tlast(o_net_tlast), .i_net_tready(i_net_tready),
        .o_acks_sent(o_acks_sent)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic [63:0]  u;
        logic         l;
    } beat_t;

    typedef struct {
        logic [3:0][31:0] seq;
        logic [3:0]       vld;
        logic             exp_ack;
        logic [31:0]      exp_seq;
        int               lat_min;
        int               lat_max;
    } rec_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    beat_t       q_app[$];
    logic [31:0] q_ack[$];
    int          grant_q[$];
    logic [31:0] seq_log[int];
    logic [31:0] m_last = 32'd0;

    int acks_seen = 0;
    int app_beats_seen = 0;
    int ack_cyc = 0;
    int prev_app_cyc = 0;
    int last_tlast_cyc = 0;
    bit in_pkt = 0;
    bit chk_contig = 0;
    bit t5_mode = 0;
    bit t5_run = 0;
    int exp_total = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [511:0] mk_ack(input logic [31:0] s);
        logic [511:0] a;
        a = '0;
        a[344 +: 32] = s;
        a[376] = 1'b1;
        return a;
    endfunction

    function automatic rec_t mk_rec(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                                    input logic [31:0] s3, input logic [3:0] v, input logic e,
                                    input logic [31:0] es, input int lmin, input int lmax);
        rec_t r;
        r.seq = {s3, s2, s1, s0};
        r.vld = v;
        r.exp_ack = e;
        r.exp_seq = es;
        r.lat_min = lmin;
        r.lat_max = lmax;
        return r;
    endfunction

    // Output monitor: sampled on the falling edge, a beat counts when valid and ready are both high.
    always @(negedge i_clk) begin
        if (!i_resetn) begin
            in_pkt = 0;
        end else if (o_net_tvalid && i_net_tready) begin
            if (o_net_tuser != 64'd0) begin
                if (q_app.size() == 0) begin
                    chk("app_unexpected", 1'b0, o_net_tdata[63:0], 64'd0);
                end else begin
                    beat_t e;
                    e = q_app.pop_front();
                    chk("app_beat", (o_net_tdata == e.d) && (o_net_tkeep == e.k) && (o_net_tuser == e.u)
                        && (o_net_tlast == e.l), o_net_tuser, e.u);
                end
                if (chk_contig && in_pkt)
                    chk("t3_contig", cyc == prev_app_cyc + 1, 64'(cyc), 64'(prev_app_cyc + 1));
                prev_app_cyc = cyc;
                in_pkt = !o_net_tlast;
                app_beats_seen++;
                if (o_net_tlast) begin
                    last_tlast_cyc = cyc;
                    if (t5_mode) grant_q.push_back(0);
                end
            end else begin
                logic [31:0] es;
                if (t5_mode) begin
                    es = seq_log.exists(cyc - 2) ? seq_log[cyc - 2] : 32'hDEAD_BEEF;
                    grant_q.push_back(1);
                end else if (q_ack.size() == 0) begin
                    es = 32'hDEAD_BEEF;
                    chk("ack_unexpected", 1'b0, 64'(o_net_tdata[344 +: 32]), 64'd0);
                end else begin
                    es = q_ack.pop_front();
                end
                chk("ack_beat", (o_net_tdata == mk_ack(es)) && (o_net_tkeep == 64'hFFFF_FFFF_FFFF_FFFF)
                    && o_net_tlast, 64'(o_net_tdata[344 +: 32]), 64'(es));
                ack_cyc = cyc;
                acks_seen++;
            end
        end
    end

    task automatic drv_seq(input logic [31:0] v, input logic vld);
        i_seq_expected = v;
        i_seq_valid = vld;
        if (vld) m_last = v;
        seq_log[cyc] = m_last;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] id, input int nb, input int last_idx, input bit keep);
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            int w;
            e.d = {16{$urandom()}};
            e.k = {56'hFF_FFFF_FFFF_FFFF, 8'(b)};
            e.u = {1'b1, 47'd0, id, 8'(b)};
            e.l = (b == last_idx);
            i_app_tvalid = 1'b1;
            i_app_tdata = e.d;
            i_app_tkeep = e.k;
            i_app_tuser = e.u;
            i_app_tlast = e.l;
            q_app.push_back(e);
            w = 0;
            @(negedge i_clk);
            while (!o_app_tready && w < 100) begin
                @(negedge i_clk);
                w++;
            end
            chk("pkt_ready", w < 100, 64'(w), 64'd100);
            tick();
        end
        if (!keep) begin
            i_app_tvalid = 1'b0;
            i_app_tlast = 1'b0;
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int w;
        w = 0;
        while (acks_seen < target && w < budget) begin
            @(negedge i_clk);
            w++;
        end
        chk("ack_arrival", acks_seen >= target, 64'(acks_seen), 64'(target));
    endtask

    rec_t recs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, base, t_first, w;
        logic [31:0] ctr;
        int exp_order[5];

        recs[0] = mk_rec(32'h5, 32'h6, 32'h7, 32'h8, 4'b1111, 1'b1, 32'h8, 4, 6);
        recs[1] = mk_rec(32'h8, 32'h8, 32'h8, 32'h8, 4'b1111, 1'b0, 32'h0, 0, 0);
        recs[2] = mk_rec(32'h9, 32'h9, 32'h9, 32'h9, 4'b1111, 1'b1, 32'h9, 17, 19);
        recs[3] = mk_rec(32'hA, 32'hB, 32'hC, 32'hD, 4'b0000, 1'b0, 32'h0, 0, 0);
        recs[4] = mk_rec(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'b1111, 1'b1, 32'h0, 4, 6);
        recs[5] = mk_rec(32'h1, 32'h1, 32'h2, 32'h2, 4'b0101, 1'b1, 32'h2, 17, 19);
        recs[6] = mk_rec(32'h3, 32'h4, 32'h3, 32'h4, 4'b1111, 1'b1, 32'h4, 4, 6);
        recs[7] = mk_rec(32'h7, 32'h7, 32'h7, 32'h7, 4'b1000, 1'b1, 32'h7, 20, 22);

        i_resetn = 1'b0;
        i_seq_expected = 32'd0;
        i_seq_valid = 1'b0;
        i_app_tdata = '0;
        i_app_tkeep = '0;
        i_app_tuser = '0;
        i_app_tvalid = 1'b0;
        i_app_tlast = 1'b0;
        i_net_tready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_net_tvalid", o_net_tvalid == 1'b0, 64'(o_net_tvalid), 64'd0);
        chk("rst_app_tready", o_app_tready == 1'b0, 64'(o_app_tready), 64'd0);
        chk("rst_acks_sent", o_acks_sent == 32'd0, 64'(o_acks_sent), 64'd0);
        tick();
        i_resetn = 1'b1;
        tick();

        // Coalescing table: threshold, duplicates, timeout, seq_valid low, wrap-around.
        for (int r = 0; r < 8; r++) begin
            c0 = cyc;
            base = acks_seen;
            if (recs[r].exp_ack) begin
                q_ack.push_back(recs[r].exp_seq);
                exp_total++;
            end
            for (int k = 0; k < 4; k++) begin
                drv_seq(recs[r].seq[k], recs[r].vld[k]);
                tick();
            end
            i_seq_valid = 1'b0;
            repeat (30) tick();
            chk("rec_ack_count", (acks_seen - base) == (recs[r].exp_ack ? 1 : 0),
                64'(acks_seen - base), 64'(recs[r].exp_ack));
            if (recs[r].exp_ack)
                chk("rec_latency", (ack_cyc - c0 >= recs[r].lat_min) && (ack_cyc - c0 <= recs[r].lat_max),
                    64'(ack_cyc - c0), 64'(recs[r].lat_min));
            chk("rec_acks_sent", o_acks_sent == 32'(exp_total), 64'(o_acks_sent), 64'(exp_total));
        end

        // No preemption: threshold reached mid-packet, ACK waits for tlast plus one idle cycle.
        chk_contig = 1;
        base = acks_seen;
        fork
            send_pkt(8'h03, 8, 7, 1'b0);
            begin
                w = 0;
                while (app_beats_seen < 2 && w < 100) begin
                    @(negedge i_clk);
                    w++;
                end
                tick();
                q_ack.push_back(32'h23);
                for (int k = 0; k < 4; k++) begin
                    drv_seq(32'h20 + 32'(k), 1'b1);
                    tick();
                end
                i_seq_valid = 1'b0;
            end
        join
        wait_acks(base + 1, 60);
        chk("t3_ack_gap", ack_cyc - last_tlast_cyc == 2, 64'(ack_cyc - last_tlast_cyc), 64'd2);
        exp_total++;
        chk("t3_acks_sent", o_acks_sent == 32'(exp_total), 64'(o_acks_sent), 64'(exp_total));
        chk_contig = 0;

        // Backpressure: ACK beat must hold its snapshot while seq moves on underneath it.
        tick();
        base = acks_seen;
        i_net_tready = 1'b0;
        q_ack.push_back(32'h8);
        for (int k = 0; k < 4; k++) begin
            drv_seq(32'h5 + 32'(k), 1'b1);
            tick();
        end
        i_seq_valid = 1'b0;
        w = 0;
        @(negedge i_clk);
        while (!o_net_tvalid && w < 20) begin
            @(negedge i_clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t4_stable", o_net_tvalid && (o_net_tdata == mk_ack(32'h8)), 64'(o_net_tdata[344 +: 32]), 64'h8);
            tick();
            if (i == 3) drv_seq(32'h9, 1'b1);
            if (i == 4) i_seq_valid = 1'b0;
            @(negedge i_clk);
        end
        q_ack.push_back(32'h9);
        tick();
        i_net_tready = 1'b1;
        wait_acks(base + 1, 10);
        t_first = ack_cyc;
        wait_acks(base + 2, 60);
        chk("t4_second_by_timeout", (ack_cyc - t_first >= 16) && (ack_cyc - t_first <= 20),
            64'(ack_cyc - t_first), 64'd18);
        exp_total += 2;
        chk("t4_acks_sent", o_acks_sent == 32'(exp_total), 64'(o_acks_sent), 64'(exp_total));

        // Round-robin: ACK becomes due in the same cycle app asks, right after an ACK grant.
        tick();
        t5_mode = 1;
        ctr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            drv_seq(ctr, 1'b1);
            ctr++;
            tick();
        end
        t5_run = 1;
        fork
            begin
                for (int p = 0; p < 3; p++) send_pkt(8'h50 + 8'(p), 3, 2, 1'b1);
                i_app_tvalid = 1'b0;
                i_app_tlast = 1'b0;
                t5_run = 0;
            end
            begin
                while (t5_run) begin
                    drv_seq(ctr, 1'b1);
                    ctr++;
                    tick();
                end
                for (int k = 0; k < 40; k++) begin
                    drv_seq(m_last, 1'b0);
                    tick();
                end
            end
        join
        exp_order = '{0, 1, 0, 1, 0};
        for (int k = 0; k < 5; k++)
            chk("t5_order", (grant_q.size() > k) && (grant_q[k] == exp_order[k]),
                64'(grant_q.size() > k ? grant_q[k] : -1), 64'(exp_order[k]));
        t5_mode = 0;

        // Async reset while an app packet is stalled mid-flight.
        send_pkt(8'h60, 2, 7, 1'b1);
        i_app_tdata = {16{32'hBAD0_0002}};
        i_net_tready = 1'b0;
        repeat (3) @(posedge i_clk);
        #3;
        chk("t6_stalled_vld", o_net_tvalid == 1'b1, 64'(o_net_tvalid), 64'd1);
        i_resetn = 1'b0;
        #1;
        chk("t6_rst_vld", o_net_tvalid == 1'b0, 64'(o_net_tvalid), 64'd0);
        chk("t6_rst_acks", o_acks_sent == 32'd0, 64'(o_acks_sent), 64'd0);
        i_net_tready = 1'b1;
        #1;
        chk("t6_rst_ready", o_app_tready == 1'b0, 64'(o_app_tready), 64'd0);
        i_app_tvalid = 1'b0;
        i_app_tlast = 1'b0;
        m_last = 32'd0;
        tick();
        i_resetn = 1'b1;
        @(negedge i_clk);
        chk("t6_idle_after", (o_net_tvalid == 1'b0) && (o_app_tready == 1'b0), 64'(o_net_tvalid), 64'd0);
        tick();
        send_pkt(8'h70, 1, 0, 1'b0);
        base = acks_seen;
        q_ack.push_back(32'h3);
        for (int k = 0; k < 4; k++) begin
            drv_seq(32'(k), 1'b1);
            tick();
        end
        i_seq_valid = 1'b0;
        wait_acks(base + 1, 30);
        repeat (3) tick();
        chk("t6_acks_sent", o_acks_sent == 32'd1, 64'(o_acks_sent), 64'd1);

        chk("end_app_queue", q_app.size() == 0, 64'(q_app.size()), 64'd0);
        chk("end_ack_queue", q_ack.size() == 0, 64'(q_ack.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
